// File: rtl/xcorr_pkg.sv
// Shared definitions for the Rx sign correlator: default reference taps,
// width helpers and the per-stage pipeline tag.
package xcorr_pkg;

    localparam logic [63:0] REF_I_D = 64'hB4E1_9A3C_5D07_F268;
    localparam logic [63:0] REF_Q_D = 64'h63D8_0FA5_C172_9B4E;

    localparam int unsigned FRAME_LEN_D = 2048;

    function automatic int unsigned corr_w(input int unsigned data_w, input int unsigned ref_len);
        return data_w + $clog2(ref_len) + 2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned frame_len);
        return $clog2(frame_len);
    endfunction

    localparam int unsigned TAG_IDX_W = $clog2(FRAME_LEN_D);

    typedef struct packed {
        logic                 valid;
        logic                 eop;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/xcorr_sign_sum.sv
// Combinational signed sum of REF_LEN taps, each added or subtracted
// according to a fixed sign mask (bit k = 1 adds tap k).
module xcorr_sign_sum #(
    parameter int unsigned        DATA_WIDTH = 12,
    parameter int unsigned        REF_LEN    = 64,
    parameter int unsigned        OUT_W      = 20,
    parameter logic [REF_LEN-1:0] SIGNS      = '1
) (
    input  logic [REF_LEN*DATA_WIDTH-1:0] taps_i,
    output logic signed [OUT_W-1:0]       sum_o
);

    always_comb begin
        sum_o = '0;
        for (int unsigned k = 0; k < REF_LEN; k++) begin
            if (SIGNS[k]) begin
                sum_o = sum_o + OUT_W'(signed'(taps_i[k*DATA_WIDTH +: DATA_WIDTH]));
            end else begin
                sum_o = sum_o - OUT_W'(signed'(taps_i[k*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
    end

endmodule

// File: rtl/xcorr_sign_correlator.sv
// Sliding +/-1 +/-j complex correlator with per-frame peak tracking.
// Optional XCORR_THRESH_EN adds a `thresh` input; det then means peak_val >= thresh.
module xcorr_sign_correlator import xcorr_pkg::*; #(
    parameter int unsigned        DATA_WIDTH = 12,
    parameter int unsigned        REF_LEN    = 64,
    parameter int unsigned        FRAME_LEN  = FRAME_LEN_D,
    parameter logic [REF_LEN-1:0] REF_I      = REF_I_D,
    parameter logic [REF_LEN-1:0] REF_Q      = REF_Q_D,
    localparam int unsigned       CORR_W     = corr_w(DATA_WIDTH, REF_LEN),
    localparam int unsigned       IDX_W      = idx_w(FRAME_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_q,
    input  logic                         in_valid,
    input  logic                         in_eop,
`ifdef XCORR_THRESH_EN
    input  logic [CORR_W-1:0]            thresh,
`endif
    output logic [CORR_W-1:0]            corr_mag,
    output logic                         corr_valid,
    output logic [CORR_W-1:0]            peak_val,
    output logic [IDX_W-1:0]             peak_idx,
    output logic                         peak_valid,
    output logic                         det
);

    localparam int unsigned LINE_W = REF_LEN * DATA_WIDTH;
    localparam int unsigned FILL_W = $clog2(REF_LEN) + 1;

    function automatic logic [CORR_W-1:0] abs_u(input logic signed [CORR_W-1:0] v);
        return v[CORR_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic [LINE_W-1:0]        dl_i_q, dl_i_d, dl_q_q, dl_q_d;
    logic                     clr_q, clr_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    tag_t                     s1_q, s1_d, s2_q;
    logic signed [CORR_W-1:0] sum_ia, sum_qb, sum_qa, sum_ib;
    logic signed [CORR_W-1:0] re_q, im_q;
    logic [CORR_W-1:0]        mag_q, mag_d;
    logic                     cv_q;
    logic [CORR_W-1:0]        pk_val_q, pk_val_d;
    logic [IDX_W-1:0]         pk_idx_q, pk_idx_d;
    logic                     seen_q, seen_d;
    logic                     pv_q, pv_d;
    logic                     det_q, det_d;

    // The delay line is not wiped at eop: S2 still needs the closed frame's
    // window, so the clear is deferred to the next shift via clr_q.
    always_comb begin
        dl_i_d = dl_i_q;
        dl_q_d = dl_q_q;
        clr_d  = clr_q;
        fill_d = fill_q;
        idx_d  = idx_q;
        s1_d     = '0;
        s1_d.eop = in_eop;
        s1_d.idx = TAG_IDX_W'(idx_q);
        if (in_valid) begin
            if (clr_q) begin
                dl_i_d = {{(LINE_W-DATA_WIDTH){1'b0}}, in_data_i};
                dl_q_d = {{(LINE_W-DATA_WIDTH){1'b0}}, in_data_q};
            end else begin
                dl_i_d = {dl_i_q[LINE_W-DATA_WIDTH-1:0], in_data_i};
                dl_q_d = {dl_q_q[LINE_W-DATA_WIDTH-1:0], in_data_q};
            end
            s1_d.valid = (fill_q >= FILL_W'(REF_LEN - 1));
            if (fill_q != FILL_W'(REF_LEN)) begin
                fill_d = fill_q + 1'b1;
            end
            idx_d = idx_q + 1'b1;
            clr_d = 1'b0;
        end
        if (in_eop) begin
            fill_d = '0;
            idx_d  = '0;
            clr_d  = 1'b1;
        end
    end

    xcorr_sign_sum #(.DATA_WIDTH(DATA_WIDTH), .REF_LEN(REF_LEN), .OUT_W(CORR_W), .SIGNS(REF_I))
        u_sum_ia (.taps_i(dl_i_q), .sum_o(sum_ia));
    xcorr_sign_sum #(.DATA_WIDTH(DATA_WIDTH), .REF_LEN(REF_LEN), .OUT_W(CORR_W), .SIGNS(REF_Q))
        u_sum_qb (.taps_i(dl_q_q), .sum_o(sum_qb));
    xcorr_sign_sum #(.DATA_WIDTH(DATA_WIDTH), .REF_LEN(REF_LEN), .OUT_W(CORR_W), .SIGNS(REF_I))
        u_sum_qa (.taps_i(dl_q_q), .sum_o(sum_qa));
    xcorr_sign_sum #(.DATA_WIDTH(DATA_WIDTH), .REF_LEN(REF_LEN), .OUT_W(CORR_W), .SIGNS(REF_Q))
        u_sum_ib (.taps_i(dl_i_q), .sum_o(sum_ib));

    // Tracker updates on the same edge that loads S3, so at the eop pulse it
    // already includes the sample shown on corr_mag; it restarts after a pulse.
    always_comb begin
        mag_d    = abs_u(re_q) + abs_u(im_q);
        pk_val_d = pv_q ? '0 : pk_val_q;
        pk_idx_d = pv_q ? '0 : pk_idx_q;
        seen_d   = pv_q ? 1'b0 : seen_q;
        if (s2_q.valid && (!seen_d || mag_d > pk_val_d)) begin
            pk_val_d = mag_d;
            pk_idx_d = IDX_W'(s2_q.idx);
            seen_d   = 1'b1;
        end
        pv_d = s2_q.eop;
`ifdef XCORR_THRESH_EN
        det_d = s2_q.eop && (pk_val_d >= thresh);
`else
        det_d = s2_q.eop && seen_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_i_q   <= '0;
            dl_q_q   <= '0;
            clr_q    <= 1'b0;
            fill_q   <= '0;
            idx_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            re_q     <= '0;
            im_q     <= '0;
            mag_q    <= '0;
            cv_q     <= 1'b0;
            pk_val_q <= '0;
            pk_idx_q <= '0;
            seen_q   <= 1'b0;
            pv_q     <= 1'b0;
            det_q    <= 1'b0;
        end else begin
            dl_i_q   <= dl_i_d;
            dl_q_q   <= dl_q_d;
            clr_q    <= clr_d;
            fill_q   <= fill_d;
            idx_q    <= idx_d;
            s1_q     <= s1_d;
            s2_q     <= s1_q;
            re_q     <= sum_ia + sum_qb;
            im_q     <= sum_qa - sum_ib;
            mag_q    <= mag_d;
            cv_q     <= s2_q.valid;
            pk_val_q <= pk_val_d;
            pk_idx_q <= pk_idx_d;
            seen_q   <= seen_d;
            pv_q     <= pv_d;
            det_q    <= det_d;
        end
    end

    assign corr_mag   = mag_q;
    assign corr_valid = cv_q;
    assign peak_val   = pk_val_q;
    assign peak_idx   = pk_idx_q;
    assign peak_valid = pv_q;
    assign det        = det_q;

endmodule

// File: tb/tb_xcorr_sign_correlator.sv
// Directed bench for xcorr_sign_correlator: a per-sample window model predicts
// every corr/peak output cycle by cycle; literal values pin the headline cases.
module tb_xcorr_sign_correlator;
    import xcorr_pkg::*;

    localparam int DW  = 12;
    localparam int RL  = 64;
    localparam int FL  = 2048;
    localparam int CW  = DW + 6 + 2;
    localparam int IW  = 11;
    localparam int ARR = 16384;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [DW-1:0] tb_di = '0;
    logic signed [DW-1:0] tb_dq = '0;
    logic                 tb_valid = 1'b0;
    logic                 tb_eop = 1'b0;
    logic [CW-1:0]        corr_mag;
    logic                 corr_valid;
    logic [CW-1:0]        peak_val;
    logic [IW-1:0]        peak_idx;
    logic                 peak_valid;
    logic                 det;
`ifdef XCORR_THRESH_EN
    logic [CW-1:0]        thresh = 1;
`endif

    always #5 clk = ~clk;

    xcorr_sign_correlator #(.DATA_WIDTH(DW), .REF_LEN(RL), .FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data_i  (tb_di),
        .in_data_q  (tb_dq),
        .in_valid   (tb_valid),
        .in_eop     (tb_eop),
`ifdef XCORR_THRESH_EN
        .thresh     (thresh),
`endif
        .corr_mag   (corr_mag),
        .corr_valid (corr_valid),
        .peak_val   (peak_val),
        .peak_idx   (peak_idx),
        .peak_valid (peak_valid),
        .det        (det)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit  exp_cv [ARR];
    int  exp_mag[ARR];
    bit  exp_pv [ARR];
    int  exp_pval[ARR];
    int  exp_pidx[ARR];
    bit  exp_det[ARR];

    int  fI[FL];
    int  fQ[FL];
    int  cnt = 0, best = 0, bidx = 0;
    bit  seen = 1'b0;
    logic [63:0] ri, rq;

    int  n_chk = 0, n_fail = 0, cv_cnt = 0;
    int  obs_val[$], obs_idx[$], obs_det[$];

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Frame-level model: each valid sample with a full window yields one
    // correlation 3 cycles later; eop yields the frame's first strict maximum.
    task automatic model(input int unsigned c, input bit v, input int di, input int dq, input bit e);
        int re, im, mag, s, q;
        if (v) begin
            fI[cnt] = di;
            fQ[cnt] = dq;
            if (cnt >= RL - 1) begin
                re = 0;
                im = 0;
                for (int k = 0; k < RL; k++) begin
                    s = fI[cnt-k];
                    q = fQ[cnt-k];
                    re += ri[k] ? s : -s;
                    re += rq[k] ? q : -q;
                    im += ri[k] ? q : -q;
                    im -= rq[k] ? s : -s;
                end
                mag = iabs(re) + iabs(im);
                exp_cv[c+3]  = 1'b1;
                exp_mag[c+3] = mag;
                if (!seen || mag > best) begin
                    best = mag;
                    bidx = cnt;
                    seen = 1'b1;
                end
            end
            cnt++;
        end
        if (e) begin
            exp_pv[c+3]   = 1'b1;
            exp_pval[c+3] = best;
            exp_pidx[c+3] = bidx;
`ifdef XCORR_THRESH_EN
            exp_det[c+3]  = (best >= 1);
`else
            exp_det[c+3]  = seen;
`endif
            cnt  = 0;
            best = 0;
            bidx = 0;
            seen = 1'b0;
        end
    endtask

    task automatic drive(input bit v, input int di, input int dq, input bit e);
        @(posedge clk);
        #1;
        tb_valid = v;
        tb_di    = DW'(di);
        tb_dq    = DW'(dq);
        tb_eop   = e;
        model(cyc, v, di, dq, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
    endtask

    // Reference-matched bursts whose window aligns exactly at a1 (and a2).
    task automatic pat_frame(input int len, input int a1, input int a2);
        int vi, vq;
        for (int n = 0; n < len; n++) begin
            vi = 0;
            vq = 0;
            if (n <= a1 && n >= a1 - 63) begin
                vi = ri[a1-n] ? 100 : -100;
                vq = rq[a1-n] ? 100 : -100;
            end
            if (n <= a2 && n >= a2 - 63) begin
                vi = ri[a2-n] ? 100 : -100;
                vq = rq[a2-n] ? 100 : -100;
            end
            drive(1'b1, vi, vq, n == len - 1);
        end
    endtask

    task automatic rand_samples(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048, 1'b0);
    endtask

    task automatic pop_peak(input string name, input int v, input int idx, input int d);
        n_chk++;
        if (obs_val.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got no peak_valid pulse, expected one", name);
        end else begin
            n_chk--;
            chk({name, "_val"}, obs_val.pop_front(), v);
            chk({name, "_idx"}, obs_idx.pop_front(), idx);
            chk({name, "_det"}, obs_det.pop_front(), d);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < ARR) begin
            chk("corr_valid", int'(corr_valid), int'(exp_cv[cyc]));
            if (exp_cv[cyc] && corr_valid) chk("corr_mag", int'(corr_mag), exp_mag[cyc]);
            chk("peak_valid", int'(peak_valid), int'(exp_pv[cyc]));
            if (exp_pv[cyc] && peak_valid) begin
                chk("peak_val", int'(peak_val), exp_pval[cyc]);
                chk("peak_idx", int'(peak_idx), exp_pidx[cyc]);
                chk("det", int'(det), int'(exp_det[cyc]));
            end
            if (rst) begin
                chk("rst_corr_mag", int'(corr_mag), 0);
                chk("rst_peak_val", int'(peak_val), 0);
                chk("rst_det", int'(det), 0);
            end
        end
        if (peak_valid) begin
            obs_val.push_back(int'(peak_val));
            obs_idx.push_back(int'(peak_idx));
            obs_det.push_back(int'(det));
        end
        if (corr_valid) cv_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int z_det;
        ri = REF_I_D;
        rq = REF_Q_D;
`ifdef XCORR_THRESH_EN
        z_det = 0;
`else
        z_det = 1;
`endif
        #2 rst = 1'b1;
        #1;
        chk("reset_corr_valid", int'(corr_valid), 0);
        chk("reset_corr_mag", int'(corr_mag), 0);
        chk("reset_peak_valid", int'(peak_valid), 0);
        chk("reset_peak_val", int'(peak_val), 0);
        chk("reset_peak_idx", int'(peak_idx), 0);
        chk("reset_det", int'(det), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single aligned 64-sample frame
        cv_cnt = 0;
        pat_frame(64, 63, -1000);
        idle(6);
        pop_peak("t1_peak", 12800, 63, 1);
        chk("t1_corr_count", cv_cnt, 1);

        // All-zero maximum-length frame
        cv_cnt = 0;
        for (int n = 0; n < FL; n++) drive(1'b1, 0, 0, n == FL - 1);
        idle(6);
        chk("t2_corr_count", cv_cnt, 1985);
        pop_peak("t2_peak", 0, 63, z_det);

        // Equal peaks: earliest index wins
        pat_frame(600, 100, 500);
        idle(6);
        pop_peak("t3_peak", 12800, 100, 1);

        // Back-to-back frames
        cv_cnt = 0;
        pat_frame(64, 63, -1000);
        pat_frame(70, 63, -1000);
        idle(6);
        pop_peak("t4_peak_a", 12800, 63, 1);
        pop_peak("t4_peak_b", 12800, 63, 1);
        chk("t4_corr_count", cv_cnt, 8);

        // Short frame, eop after the last sample, then an empty frame
        cv_cnt = 0;
        rand_samples(30);
        drive(1'b0, 0, 0, 1'b1);
        drive(1'b0, 0, 0, 1'b1);
        idle(6);
        chk("t5_corr_count", cv_cnt, 0);
        pop_peak("t5_short", 0, 0, 0);
        pop_peak("t5_empty", 0, 0, 0);

        // Reset in the middle of a frame
        rand_samples(1000);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        tb_valid = 1'b0;
        tb_eop   = 1'b0;
        for (int i = int'(cyc); i < ARR; i++) begin
            exp_cv[i] = 1'b0;
            exp_pv[i] = 1'b0;
        end
        cnt  = 0;
        best = 0;
        bidx = 0;
        seen = 1'b0;
        #1;
        chk("t6_rst_corr_valid", int'(corr_valid), 0);
        chk("t6_rst_corr_mag", int'(corr_mag), 0);
        chk("t6_rst_peak_val", int'(peak_val), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(6);
        chk("t6_no_pulse", obs_val.size(), 0);
        pat_frame(64, 63, -1000);
        idle(6);
        pop_peak("t6_next_frame", 12800, 63, 1);
        chk("t6_extra_pulses", obs_val.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
